draw_rect_phys_ctl: RTL and testbench

Parametrised 2-D physics controller for the draggable rectangle. The block follows the mouse and launches the rectangle on a left click, with an initial velocity taken from the mouse motion. It then applies gravity, bounces off all four screen edges with a configurable restitution, and settles at the bottom. It sits between the mouse interface and the rectangle draw stage and advances once per `frame_tick`, not per clock.

---
 rtl/draw_rect_phys_ctl.sv | 171 +++++++++++++++++
 tb/tb_draw_rect_phys_ctl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/draw_rect_phys_ctl.sv
// ==== draw_rect_phys_ctl : frame-rate follow/flight/rest physics for the draggable rectangle ==== rev 1.0
`default_nettype none

module draw_rect_phys_ctl #(
   parameter int HOR_PIXELS   = 800,
   parameter int VER_PIXELS   = 600,
   parameter int RECT_W       = 48,
   parameter int RECT_H       = 64,
   parameter int FRAC         = 4,
   parameter int VEL_W        = 16,
   parameter int GRAVITY      = 12,
   parameter int BOUNCE_NUM   = 11,
   parameter int BOUNCE_SHIFT = 4,
   parameter int STOP_SPEED   = 6,
   parameter int VMAX         = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frame_tick,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   input  logic        mouse_left,
   input  logic        rearm,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        moving,
   output logic        stop
);

   localparam int P_W     = 12 + FRAC;
   localparam int XMAX    = HOR_PIXELS - RECT_W - 1;
   localparam int YMAX    = VER_PIXELS - RECT_H - 1;
   localparam int XMAX_FP = XMAX << FRAC;
   localparam int YMAX_FP = YMAX << FRAC;
   localparam int VLIM    = VMAX << FRAC;

   typedef enum logic [1:0] {
      S_FOLLOW = 2'd0,
      S_FLIGHT = 2'd1,
      S_REST   = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [P_W-1:0]           px_q, px_d, py_q, py_d;
   logic signed [VEL_W-1:0]  vx_q, vx_d, vy_q, vy_d;
   logic [11:0]              pmx_q, pmx_d, pmy_q, pmy_d;

   logic [11:0]              mx, my;
   logic [P_W-1:0]           px_n, py_n;
   logic signed [VEL_W-1:0]  vx_n, vy_n;
   logic [1:0]               y_hit;
   int                       vy_abs;

   function automatic logic signed [VEL_W-1:0] sat_v(input int v);
      if (v > VLIM)
         return VEL_W'(VLIM);
      else if (v < -VLIM)
         return VEL_W'(-VLIM);
      else
         return VEL_W'(v);
   endfunction

   // One axis of flight: move, or pin to the wall and reflect with restitution.
   // Returns {high_wall_hit, low_wall_hit}.
   function automatic logic [1:0] axis_step(
      input  logic [P_W-1:0]          p,
      input  logic signed [VEL_W-1:0] v,
      input  int                      max_fp,
      output logic [P_W-1:0]          p_n,
      output logic signed [VEL_W-1:0] v_n
   );
      int c;
      int mag;
      c   = int'(p) + int'(v);
      mag = (((v < 0) ? -int'(v) : int'(v)) * BOUNCE_NUM) >>> BOUNCE_SHIFT;
      p_n = P_W'(c);
      v_n = v;
      axis_step = 2'b00;
      if (c < 0) begin
         p_n = '0;
         v_n = sat_v(mag);
         axis_step = 2'b01;
      end else if (c > max_fp) begin
         p_n = P_W'(max_fp);
         v_n = sat_v(-mag);
         axis_step = 2'b10;
      end
   endfunction

   always_comb begin
      mx = (mouse_xpos > 12'(XMAX)) ? 12'(XMAX) : mouse_xpos;
      my = (mouse_ypos > 12'(YMAX)) ? 12'(YMAX) : mouse_ypos;

      void'(axis_step(px_q, vx_q, XMAX_FP, px_n, vx_n));
      y_hit  = axis_step(py_q, vy_q, YMAX_FP, py_n, vy_n);
      vy_abs = (vy_q < 0) ? -int'(vy_q) : int'(vy_q);

      state_d = state_q;
      px_d    = px_q;
      py_d    = py_q;
      vx_d    = vx_q;
      vy_d    = vy_q;
      pmx_d   = pmx_q;
      pmy_d   = pmy_q;

      case (state_q)
         S_FOLLOW: begin
            if (frame_tick) begin
               px_d  = {mx, {FRAC{1'b0}}};
               py_d  = {my, {FRAC{1'b0}}};
               vx_d  = sat_v((int'(mx) - int'(pmx_q)) <<< FRAC);
               vy_d  = sat_v((int'(my) - int'(pmy_q)) <<< FRAC);
               pmx_d = mx;
               pmy_d = my;
               if (mouse_left)
                  state_d = S_FLIGHT;
            end
         end
         S_FLIGHT: begin
            if (frame_tick) begin
               px_d = px_n;
               vx_d = vx_n;
               py_d = py_n;
               // Gravity only accumulates on frames without a vertical collision.
               vy_d = (y_hit == 2'b00) ? sat_v(int'(vy_n) + GRAVITY) : vy_n;
               if (y_hit[1] && ((vy_abs >>> FRAC) <= STOP_SPEED)) begin
                  py_d    = P_W'(YMAX_FP);
                  vx_d    = '0;
                  vy_d    = '0;
                  state_d = S_REST;
               end
            end
         end
         S_REST: begin
            vx_d = '0;
            vy_d = '0;
            if (rearm)
               state_d = S_FOLLOW;
         end
         default: state_d = S_FOLLOW;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_FOLLOW;
         px_q    <= '0;
         py_q    <= '0;
         vx_q    <= '0;
         vy_q    <= '0;
         pmx_q   <= '0;
         pmy_q   <= '0;
      end else begin
         state_q <= state_d;
         px_q    <= px_d;
         py_q    <= py_d;
         vx_q    <= vx_d;
         vy_q    <= vy_d;
         pmx_q   <= pmx_d;
         pmy_q   <= pmy_d;
      end
   end

   assign xpos   = px_q[P_W-1:FRAC];
   assign ypos   = py_q[P_W-1:FRAC];
   assign moving = (state_q == S_FLIGHT);
   assign stop   = (state_q == S_REST);

endmodule

`default_nettype wire

// File: tb/tb_draw_rect_phys_ctl.sv
// ==== tb_draw_rect_phys_ctl : randomized bench with a frame-level physics reference model ==== rev 1.0
`default_nettype none

module tb_draw_rect_phys_ctl;

   localparam int XMAX    = 800 - 48 - 1;
   localparam int YMAX    = 600 - 64 - 1;
   localparam int ONE     = 16;
   localparam int VLIM    = 31 * ONE;
   localparam int M_FOLLOW = 0;
   localparam int M_FLIGHT = 1;
   localparam int M_REST   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_tick;
   logic [11:0] mouse_xpos, mouse_ypos;
   logic        mouse_left, rearm;
   logic [11:0] xpos, ypos;
   logic        moving, stop;

   always #5 clk = ~clk;

   draw_rect_phys_ctl dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .mouse_xpos (mouse_xpos),
      .mouse_ypos (mouse_ypos),
      .mouse_left (mouse_left),
      .rearm      (rearm),
      .xpos       (xpos),
      .ypos       (ypos),
      .moving     (moving),
      .stop       (stop)
   );

   int tests = 0;
   int fails = 0;

   // Reference state: positions and velocities in 1/16 pixel units
   int m_mode, m_px, m_py, m_vx, m_vy, m_pmx, m_pmy;

   task automatic check(input string tag, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v > VLIM) ? VLIM : ((v < -VLIM) ? -VLIM : v);
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic model_reset();
      m_mode = M_FOLLOW;
      m_px = 0; m_py = 0; m_vx = 0; m_vy = 0; m_pmx = 0; m_pmy = 0;
   endtask

   // Ballistic motion between two walls; hit = -1 low wall, +1 high wall
   task automatic fly(inout int p, inout int v, input int lim, output int hit);
      int c;
      int keep;
      c    = p + v;
      keep = (iabs(v) * 11) / 16;
      hit  = 0;
      if (c < 0) begin
         p = 0; v = keep; hit = -1;
      end else if (c > lim) begin
         p = lim; v = -keep; hit = 1;
      end else begin
         p = c;
      end
   endtask

   task automatic model_step(input bit tk);
      int mx, my, hx, hy, vy_before;
      if (m_mode == M_REST) begin
         m_vx = 0; m_vy = 0;
         if (rearm) m_mode = M_FOLLOW;
      end else if (tk && m_mode == M_FOLLOW) begin
         mx = (int'(mouse_xpos) > XMAX) ? XMAX : int'(mouse_xpos);
         my = (int'(mouse_ypos) > YMAX) ? YMAX : int'(mouse_ypos);
         m_px = mx * ONE;  m_py = my * ONE;
         m_vx = sat((mx - m_pmx) * ONE);
         m_vy = sat((my - m_pmy) * ONE);
         m_pmx = mx; m_pmy = my;
         if (mouse_left) m_mode = M_FLIGHT;
      end else if (tk && m_mode == M_FLIGHT) begin
         vy_before = m_vy;
         fly(m_px, m_vx, XMAX * ONE, hx);
         fly(m_py, m_vy, YMAX * ONE, hy);
         if (hy == 0) m_vy = sat(m_vy + 12);
         if (hy == 1 && iabs(vy_before) / ONE <= 6) begin
            m_py = YMAX * ONE; m_vx = 0; m_vy = 0; m_mode = M_REST;
         end
      end
   endtask

   task automatic compare();
      check("xpos",   int'(xpos),   m_px / ONE);
      check("ypos",   int'(ypos),   m_py / ONE);
      check("moving", int'(moving), (m_mode == M_FLIGHT) ? 1 : 0);
      check("stop",   int'(stop),   (m_mode == M_REST) ? 1 : 0);
   endtask

   // One clock: inputs already set, step model at the edge, compare just after it
   task automatic cyc(input bit tk);
      frame_tick = tk;
      @(posedge clk);
      model_step(tk);
      #1;
      frame_tick = 1'b0;
      compare();
   endtask

   task automatic set_mouse(input int x, input int y, input bit l);
      mouse_xpos = 12'(x);
      mouse_ypos = 12'(y);
      mouse_left = l;
   endtask

   task automatic run_flight(output bit saw_x, output bit saw_y);
      saw_x = 0; saw_y = 0;
      for (int i = 0; i < 800 && m_mode == M_FLIGHT; i++) begin
         cyc(1'b1);
         if (xpos == 12'(XMAX)) saw_x = 1;
         if (ypos == 12'(YMAX)) saw_y = 1;
      end
   endtask

   initial begin
      bit sx, sy;
      rst = 1'b1; frame_tick = 1'b0; rearm = 1'b0;
      set_mouse(0, 0, 1'b0);
      model_reset();
      #12;
      compare();
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // Follow and clamp
      set_mouse(100, 200, 1'b0); cyc(1'b1);
      check("follow_x", int'(xpos), 100);
      set_mouse(900, 700, 1'b0); cyc(1'b1);
      check("clamp_x", int'(xpos), XMAX);
      check("clamp_y", int'(ypos), YMAX);

      // Tick gating: nothing moves without frame_tick
      for (int i = 0; i < 6; i++) begin
         set_mouse($urandom_range(0, 1023), $urandom_range(0, 1023), 1'(i % 2));
         cyc(1'b0);
      end
      check("gate_moving", int'(moving), 0);

      // Free fall from the top, then settle
      set_mouse(100, 0, 1'b0); cyc(1'b1); cyc(1'b1);
      mouse_left = 1'b1; cyc(1'b1);
      mouse_left = 1'b0;
      check("launch_moving", int'(moving), 1);
      run_flight(sx, sy);
      check("fall_floor_hit", int'(sy), 1);
      check("settled", int'(stop), 1);
      for (int i = 0; i < 10; i++) cyc(1'b1);
      check("rest_hold_y", int'(ypos), YMAX);
      rearm = 1'b1; cyc(1'b0); rearm = 1'b0;
      check("rearm_stop", int'(stop), 0);

      // Right-wall bounce from a +20 px throw
      set_mouse(100, 100, 1'b0); cyc(1'b1);
      set_mouse(120, 100, 1'b1); cyc(1'b1);
      mouse_left = 1'b0;
      cyc(1'b1);
      check("throw_step", int'(xpos), 140);
      run_flight(sx, sy);
      check("right_wall_hit", int'(sx), 1);
      rearm = 1'b1; cyc(1'b0); rearm = 1'b0;

      // Saturated throw: delta 100 px -> 31 px/frame
      set_mouse(0, 300, 1'b0); cyc(1'b1);
      set_mouse(100, 300, 1'b1); cyc(1'b1);
      mouse_left = 1'b0;
      cyc(1'b1);
      check("sat_throw", int'(xpos), 131);
      cyc(1'b1); cyc(1'b1);

      // Asynchronous reset between edges
      #3 rst = 1'b1;
      #1;
      check("arst_xpos", int'(xpos), 0);
      check("arst_ypos", int'(ypos), 0);
      check("arst_moving", int'(moving), 0);
      @(posedge clk); #2 rst = 1'b0;
      model_reset();
      @(posedge clk); #1;
      compare();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         set_mouse($urandom_range(0, 1023), $urandom_range(0, 700), ($urandom_range(0, 15) == 0));
         rearm = ($urandom_range(0, 7) == 0);
         cyc($urandom_range(0, 3) != 0);
      end
      rearm = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
